// File: rtl/nios_system_sysinfo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nios_system_sysinfo_pkg                                    |
// | Description : Word map, CTRL bit and CAPS field constants for sysinfo.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package nios_system_sysinfo_pkg;

    localparam logic [3:0] ADDR_ID        = 4'd0;
    localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] ADDR_CAPS      = 4'd2;
    localparam logic [3:0] ADDR_CTRL      = 4'd3;
    localparam logic [3:0] ADDR_UPTIME_LO = 4'd4;
    localparam logic [3:0] ADDR_UPTIME_HI = 4'd5;
    localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

    localparam int CTRL_RUN_BIT   = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam logic [7:0] CAPS_VERSION = 8'h02;

    localparam int CAPS_NSCR_LSB   = 0;
    localparam int CAPS_NSCR_MSB   = 3;
    localparam int CAPS_UPTIME_BIT = 4;
    localparam int CAPS_VER_LSB    = 8;
    localparam int CAPS_VER_MSB    = 15;

    function automatic logic [31:0] caps_word(input logic [3:0] nscr, input logic uptime);
        logic [31:0] w;
        w                              = '0;
        w[CAPS_NSCR_MSB:CAPS_NSCR_LSB] = nscr;
        w[CAPS_UPTIME_BIT]             = uptime;
        w[CAPS_VER_MSB:CAPS_VER_LSB]   = CAPS_VERSION;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios_system_sysinfo_uptime.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nios_system_sysinfo_uptime                                 |
// | Description : Prescaled 64-bit uptime counter with high-word shadow.     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module nios_system_sysinfo_uptime #(
    parameter int TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        clear,
    input  logic        capture,
    output logic [31:0] lo,
    output logic [31:0] hi_shadow
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;

    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        // Shadow takes the pre-edge high word, so it pairs with the LO being read.
        if (capture) begin
            shadow_d = cnt_q[63:32];
        end
        if (clear) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (run) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                cnt_d   = cnt_q + 64'd1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign lo        = cnt_q[31:0];
    assign hi_shadow = shadow_q;

endmodule
`default_nettype wire

// File: rtl/nios_system_sysinfo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nios_system_sysinfo                                        |
// | Description : Avalon-MM read-latency-1 system information slave.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module nios_system_sysinfo
    import nios_system_sysinfo_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter int          NUM_SCRATCH = 4,
    parameter bit          UPTIME_EN   = 1'b1,
    parameter int          TICK_DIV    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic        rd_en;
    logic        wr_en;
    logic        ctrl_wr;
    logic        capture;
    logic [31:0] uptime_lo;
    logic [31:0] uptime_hi;
    logic [31:0] ctrl_word;
    logic [31:0] scratch_word [8];
    logic [31:0] rdata_d;
    logic [31:0] readdata_q;
    logic        readdatavalid_q;

    assign rd_en   = chipselect & read;
    assign wr_en   = chipselect & write;
    assign ctrl_wr = wr_en && (address == ADDR_CTRL) && byteenable[0];
    assign capture = rd_en && (address == ADDR_UPTIME_LO);

    if (UPTIME_EN) begin : g_uptime
        logic run_q, run_d;

        always_comb begin
            run_d = run_q;
            if (ctrl_wr) begin
                run_d = writedata[CTRL_RUN_BIT];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                run_q <= 1'b1;
            end else begin
                run_q <= run_d;
            end
        end

        nios_system_sysinfo_uptime #(
            .TICK_DIV (TICK_DIV)
        ) u_uptime (
            .clock     (clock),
            .reset     (reset),
            .run       (run_q),
            .clear     (ctrl_wr & writedata[CTRL_CLEAR_BIT]),
            .capture   (capture),
            .lo        (uptime_lo),
            .hi_shadow (uptime_hi)
        );

        assign ctrl_word = 32'(run_q) << CTRL_RUN_BIT;
    end else begin : g_no_uptime
        assign uptime_lo = '0;
        assign uptime_hi = '0;
        assign ctrl_word = '0;
    end

    // Slots beyond NUM_SCRATCH are tied to zero so the read mux needs no range check.
    for (genvar i = 0; i < 8; i++) begin : g_scratch
        if (i < NUM_SCRATCH) begin : g_reg
            logic [31:0] word_q, word_d;

            always_comb begin
                word_d = word_q;
                if (wr_en && (address == (ADDR_SCRATCH0 + 4'(i)))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b]) begin
                            word_d[8*b +: 8] = writedata[8*b +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign scratch_word[i] = word_q;
        end else begin : g_none
            assign scratch_word[i] = '0;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_ID:        rdata_d = SYSTEM_ID;
            ADDR_TIMESTAMP: rdata_d = TIMESTAMP;
            ADDR_CAPS:      rdata_d = caps_word(4'(NUM_SCRATCH), UPTIME_EN);
            ADDR_CTRL:      rdata_d = ctrl_word;
            ADDR_UPTIME_LO: rdata_d = uptime_lo;
            ADDR_UPTIME_HI: rdata_d = uptime_hi;
            default: begin
                if (address[3]) begin
                    rdata_d = scratch_word[address[2:0]];
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdatavalid_q <= rd_en;
            if (rd_en) begin
                readdata_q <= rdata_d;
            end
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_sysinfo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_nios_system_sysinfo                                     |
// | Description : Directed self-checking bench for nios_system_sysinfo.      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_nios_system_sysinfo;

    localparam logic [31:0] SYS_ID  = 32'h5E45_A1BF;
    localparam logic [31:0] TSTAMP  = 32'h4E45_0000;
    localparam int          NSCR    = 4;
    localparam int          TDIV    = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    int checks = 0;
    int errors = 0;

    nios_system_sysinfo #(
        .SYSTEM_ID   (SYS_ID),
        .TIMESTAMP   (TSTAMP),
        .NUM_SCRATCH (NSCR),
        .UPTIME_EN   (1'b1),
        .TICK_DIV    (TDIV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: uptime is base + (running edges since clear/preload) / TDIV.
    logic            m_run;
    logic [63:0]     m_base;
    longint unsigned m_edges;
    logic [31:0]     m_shadow;
    logic [31:0]     m_scr [NSCR];
    logic            exp_valid;
    logic [31:0]     exp_rdata;
    logic            preload_req;

    always @(posedge clock) begin
        logic [63:0] cnt;
        if (reset) begin
            m_run     = 1'b1;
            m_base    = '0;
            m_edges   = 0;
            m_shadow  = '0;
            for (int i = 0; i < NSCR; i++) m_scr[i] = '0;
            exp_valid = 1'b0;
            exp_rdata = '0;
        end else begin
            cnt = m_base + 64'(m_edges / TDIV);
            exp_valid = chipselect && read;
            if (chipselect && read) begin
                case (address)
                    4'd0: exp_rdata = SYS_ID;
                    4'd1: exp_rdata = TSTAMP;
                    4'd2: exp_rdata = {16'h0000, 8'h02, 3'b000, 1'b1, 4'(NSCR)};
                    4'd3: exp_rdata = {31'b0, m_run};
                    4'd4: exp_rdata = cnt[31:0];
                    4'd5: exp_rdata = m_shadow;
                    default: exp_rdata = (address >= 8 && address < 8 + NSCR) ? m_scr[address - 8] : 32'h0;
                endcase
                if (address == 4'd4) m_shadow = cnt[63:32];
            end
            if (m_run) m_edges++;
            if (chipselect && write) begin
                if (address == 4'd3 && byteenable[0]) begin
                    if (writedata[1]) begin
                        m_base  = '0;
                        m_edges = 0;
                    end
                    m_run = writedata[0];
                end
                if (address >= 8 && address < 8 + NSCR) begin
                    for (int b = 0; b < 4; b++)
                        if (byteenable[b]) m_scr[address - 8][8*b +: 8] = writedata[8*b +: 8];
                end
            end
            if (preload_req) begin
                m_base  = 64'h0000_0000_FFFF_FFFF;
                m_edges = 0;
            end
        end
        #1;
        chk("model_valid", {63'b0, readdatavalid}, {63'b0, exp_valid});
        chk("model_rdata", {32'b0, readdata}, {32'b0, exp_rdata});
    end

    // Bus tasks are entered on a falling edge and return on the next one.
    task automatic rd(input logic [3:0] a, output logic [31:0] d, output logic v);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clock);
        chipselect = 1'b0; read = 1'b0;
        d = readdata; v = readdatavalid;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; chipselect = 1'b1; write = 1'b1; writedata = d; byteenable = be;
        @(negedge clock);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rdchk(input logic [3:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        logic        v;
        rd(a, d, v);
        chk(name, {32'b0, d}, {32'b0, exp});
        chk({name, "_valid"}, {63'b0, v}, 64'd1);
    endtask

    initial begin
        logic [31:0] d, lo, hi, held;
        logic        v, ok;

        reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0; preload_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_rdata", {32'b0, readdata}, 64'd0);
        chk("reset_valid", {63'b0, readdatavalid}, 64'd0);
        reset = 1'b0;

        rdchk(4'd0, 32'h5E45_A1BF, "id");
        rdchk(4'd1, 32'h4E45_0000, "timestamp");
        rdchk(4'd2, 32'h0000_0214, "caps");
        rdchk(4'd3, 32'h0000_0001, "ctrl_reset");
        @(negedge clock);
        chk("valid_drops", {63'b0, readdatavalid}, 64'd0);

        wr(4'd8, 32'hDEAD_BEEF, 4'b0101);
        rdchk(4'd8, 32'h00AD_00EF, "scratch0_bytes");
        wr(4'd0, 32'hFFFF_FFFF, 4'b1111);
        rdchk(4'd0, 32'h5E45_A1BF, "id_ro");
        wr(4'd11, 32'h0123_4567, 4'b1111);
        rdchk(4'd11, 32'h0123_4567, "scratch3");
        wr(4'd12, 32'hCAFE_F00D, 4'b1111);
        rdchk(4'd12, 32'h0000_0000, "unimpl_scratch");
        rdchk(4'd6, 32'h0000_0000, "reserved6");

        // Read and write to the same word in one cycle: read sees the old value.
        address = 4'd11; chipselect = 1'b1; read = 1'b1; write = 1'b1;
        writedata = 32'h89AB_CDEF; byteenable = 4'b1111;
        @(negedge clock);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        chk("rw_old_value", {32'b0, readdata}, 64'h0123_4567);
        rdchk(4'd11, 32'h89AB_CDEF, "rw_new_value");

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rdchk(4'd4, 32'd0, "uptime_c0");
        repeat (39) @(negedge clock);
        rdchk(4'd4, 32'd10, "uptime_c40");

        wr(4'd3, 32'h2, 4'b0001);
        force dut.g_uptime.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFF;
        preload_req = 1'b1;
        @(negedge clock);
        release dut.g_uptime.u_uptime.cnt_q;
        preload_req = 1'b0;
        rdchk(4'd3, 32'h0, "ctrl_run_off");
        wr(4'd3, 32'h1, 4'b0001);
        for (int i = 0; i < 12; i++) begin
            rd(4'd4, lo, v);
            rd(4'd5, hi, v);
            ok = (hi == 32'h0 && lo == 32'hFFFF_FFFF) || (hi == 32'h1 && lo <= 32'd8);
            chk("carry_coherent", {63'b0, ok}, 64'd1);
        end

        wr(4'd3, 32'h0, 4'b0001);
        rd(4'd4, held, v);
        repeat (20) @(negedge clock);
        rd(4'd4, d, v);
        chk("run_off_hold", {32'b0, d}, {32'b0, held});
        wr(4'd3, 32'h3, 4'b0001);
        rdchk(4'd4, 32'd0, "clear_lo");
        rdchk(4'd3, 32'h1, "ctrl_run_on");

        wr(4'd8, 32'h1234_5678, 4'b1111);
        rdchk(4'd8, 32'h1234_5678, "scratch_before_rst");
        address = 4'd8; chipselect = 1'b1; read = 1'b1; reset = 1'b1;
        @(negedge clock);
        chipselect = 1'b0; read = 1'b0;
        chk("rst_read_valid", {63'b0, readdatavalid}, 64'd0);
        chk("rst_read_data", {32'b0, readdata}, 64'd0);
        reset = 1'b0;
        rdchk(4'd8, 32'h0, "rst_scratch");
        rdchk(4'd4, 32'h0, "rst_uptime");

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
